// File: rtl/dds_pkg.sv
// Shared DDS widths and sweep state encoding.
// Used by the DDS, the sweep controller and the register bank.
package dds_pkg;

   localparam int FW_W  = 24;
   localparam int DIV_W = 16;
   localparam int CNT_W = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } sweep_state_t;

endpackage

// File: rtl/dds_tick_gen.sv
// Free-running sample-tick divider: one-cycle pulse every div+1 cycles.
// div is sampled live; lowering it below the count forces an early tick.
module dds_tick_gen #(
   parameter int DIV_W = dds_pkg::DIV_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] div,
   output logic             int_dff_en
);

   logic [DIV_W-1:0] div_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt    <= '0;
         int_dff_en <= 1'b0;
      end else if (div_cnt >= div) begin
         div_cnt    <= '0;
         int_dff_en <= 1'b1;
      end else begin
         div_cnt    <= div_cnt + 1'b1;
         int_dff_en <= 1'b0;
      end
   end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS sweep sequencer: steps freq_word through a linear sweep,
// advancing once every dwell+1 sample ticks.
module dds_sweep_ctrl #(
   parameter int FW_W  = dds_pkg::FW_W,
   parameter int DIV_W = dds_pkg::DIV_W,
   parameter int CNT_W = dds_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] div,
   input  logic             start,
   input  logic             abort,
   input  logic             loop_en,
   input  logic [FW_W-1:0]  f_start,
   input  logic [FW_W-1:0]  f_step,
   input  logic [CNT_W-1:0] n_steps,
   input  logic [CNT_W-1:0] dwell,
   output logic             int_dff_en,
   output logic [FW_W-1:0]  freq_word,
   output logic             busy,
   output logic             done
);

   import dds_pkg::*;

   sweep_state_t     state;
   logic             tick;
   logic             loop_q;
   logic [FW_W-1:0]  f_start_q;
   logic [FW_W-1:0]  f_step_q;
   logic [CNT_W-1:0] n_steps_q;
   logic [CNT_W-1:0] dwell_q;
   logic [CNT_W-1:0] dwell_cnt;
   logic [CNT_W-1:0] step_cnt;

   dds_tick_gen #(
      .DIV_W(DIV_W)
   ) u_tick (
      .clk       (clk),
      .rst_n     (rst_n),
      .div       (div),
      .int_dff_en(tick)
   );

   assign int_dff_en = tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         freq_word <= '0;
         loop_q    <= 1'b0;
         f_start_q <= '0;
         f_step_q  <= '0;
         n_steps_q <= '0;
         dwell_q   <= '0;
         dwell_cnt <= '0;
         step_cnt  <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start && !abort) begin
                  loop_q    <= loop_en;
                  f_start_q <= f_start;
                  f_step_q  <= f_step;
                  n_steps_q <= n_steps;
                  dwell_q   <= dwell;
                  freq_word <= f_start;
                  dwell_cnt <= '0;
                  step_cnt  <= '0;
                  busy      <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               // abort outranks a coincident tick
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (tick) begin
                  if (dwell_cnt < dwell_q) begin
                     dwell_cnt <= dwell_cnt + 1'b1;
                  end else begin
                     dwell_cnt <= '0;
                     if (step_cnt < n_steps_q) begin
                        freq_word <= freq_word + f_step_q;
                        step_cnt  <= step_cnt + 1'b1;
                     end else if (loop_q) begin
                        freq_word <= f_start_q;
                        step_cnt  <= '0;
                     end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl with a per-cycle expectation queue.
// A small tick model predicts sample-tick phase for non-zero div.
module tb_dds_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] div;
   logic        start;
   logic        abort;
   logic        loop_en;
   logic [23:0] f_start;
   logic [23:0] f_step;
   logic [15:0] n_steps;
   logic [15:0] dwell;
   logic        int_dff_en;
   logic [23:0] freq_word;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;
   int pulses;

   typedef struct packed {
      logic        busy;
      logic        done;
      logic [23:0] freq;
   } exp_t;

   exp_t q[$];

   logic [15:0] m_cnt;
   logic        m_en;

   always #5 clk = ~clk;

   dds_sweep_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .div       (div),
      .start     (start),
      .abort     (abort),
      .loop_en   (loop_en),
      .f_start   (f_start),
      .f_step    (f_step),
      .n_steps   (n_steps),
      .dwell     (dwell),
      .int_dff_en(int_dff_en),
      .freq_word (freq_word),
      .busy      (busy),
      .done      (done)
   );

   // reference tick: one pulse the cycle after the count reaches div
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt <= '0;
         m_en  <= 1'b0;
      end else if (m_cnt >= div) begin
         m_cnt <= '0;
         m_en  <= 1'b1;
      end else begin
         m_cnt <= m_cnt + 16'd1;
         m_en  <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic go(input logic [23:0] fs, input logic [23:0] st,
                     input int n, input int d, input logic lp);
      f_start = fs;
      f_step  = st;
      n_steps = 16'(n);
      dwell   = 16'(d);
      loop_en = lp;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   // expected outputs per cycle from the cycle after the start edge
   task automatic push_seq(input logic [23:0] fs, input logic [23:0] st,
                           input int n, input int d, input bit lp,
                           input int ncyc);
      int          ticks;
      int          k;
      int          idx;
      int          tot;
      logic [15:0] c;
      logic        en;
      logic [23:0] f;
      exp_t        e;
      ticks = 0;
      k     = 0;
      tot   = (n + 1) * (d + 1);
      c     = m_cnt;
      en    = m_en;
      while ((lp ? (k < ncyc) : (ticks < tot)) && k < 5000) begin
         idx    = (ticks / (d + 1)) % (n + 1);
         f      = fs + 24'(idx) * st;
         e.busy = 1'b1;
         e.done = 1'b0;
         e.freq = f;
         q.push_back(e);
         if (en) ticks++;
         if (c >= div) begin
            en = 1'b1;
            c  = '0;
         end else begin
            en = 1'b0;
            c  = c + 16'd1;
         end
         k++;
      end
      if (!lp) begin
         f      = fs + 24'(n) * st;
         e.busy = 1'b0;
         e.done = 1'b1;
         e.freq = f;
         q.push_back(e);
         e.done = 1'b0;
         q.push_back(e);
      end
   endtask

   task automatic run_q(input string tag);
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         chk({tag, ".freq"}, 32'(freq_word), 32'(e.freq));
         chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
         chk({tag, ".done"}, 32'(done), 32'(e.done));
         chk({tag, ".tick"}, 32'(int_dff_en), 32'(m_en));
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      div     = 16'd3;
      start   = 1'b0;
      abort   = 1'b0;
      loop_en = 1'b0;
      f_start = '0;
      f_step  = '0;
      n_steps = '0;
      dwell   = '0;
      repeat (3) @(negedge clk);
      chk("rst.freq", 32'(freq_word), 32'h0);
      chk("rst.busy", 32'(busy), 32'h0);
      chk("rst.done", 32'(done), 32'h0);
      chk("rst.tick", 32'(int_dff_en), 32'h0);

      rst_n  = 1'b1;
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("div3.tick", 32'(int_dff_en), 32'(i % 4 == 3));
         pulses += int'(int_dff_en);
      end
      chk("div3.count", 32'(pulses), 32'd4);

      div = 16'd0;
      repeat (2) @(negedge clk);
      go(24'h000100, 24'h000010, 3, 1, 1'b0);
      push_seq(24'h000100, 24'h000010, 3, 1, 1'b0, 0);
      run_q("single");

      go(24'hFFFFF0, 24'h000010, 2, 0, 1'b1);
      push_seq(24'hFFFFF0, 24'h000010, 2, 0, 1'b1, 9);
      run_q("loop");
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("loop_abort.busy", 32'(busy), 32'h0);
      chk("loop_abort.done", 32'(done), 32'h0);
      chk("loop_abort.freq", 32'(freq_word), 32'hFFFFF0);

      go(24'h000005, 24'hFFFFFF, 5, 0, 1'b0);
      push_seq(24'h000005, 24'hFFFFFF, 5, 0, 1'b0, 0);
      run_q("neg");

      go(24'h000100, 24'h000010, 3, 1, 1'b0);
      push_seq(24'h000100, 24'h000010, 3, 1, 1'b0, 0);
      while (q.size() > 4) void'(q.pop_back());
      run_q("abort_pre");
      f_start = 24'hABCDEF;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      chk("run_start.freq", 32'(freq_word), 32'h000120);
      chk("run_start.busy", 32'(busy), 32'h1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort.busy", 32'(busy), 32'h0);
      chk("abort.done", 32'(done), 32'h0);
      chk("abort.freq", 32'(freq_word), 32'h000120);
      repeat (2) begin
         @(negedge clk);
         chk("abort_hold.done", 32'(done), 32'h0);
         chk("abort_hold.freq", 32'(freq_word), 32'h000120);
      end

      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort.busy", 32'(busy), 32'h0);
      chk("start_abort.freq", 32'(freq_word), 32'h000120);
      @(negedge clk);
      chk("start_abort.busy2", 32'(busy), 32'h0);

      go(24'h000100, 24'h000010, 3, 1, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst.busy", 32'(busy), 32'h0);
      chk("async_rst.freq", 32'(freq_word), 32'h0);
      chk("async_rst.tick", 32'(int_dff_en), 32'h0);

      div = 16'd9;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk("div9.tick", 32'(int_dff_en), 32'h0);
      end
      div = 16'd2;
      @(negedge clk);
      chk("div_live.tick", 32'(int_dff_en), 32'h1);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk("div2.tick", 32'(int_dff_en), 32'(i % 3 == 2));
      end

      go(24'h000010, 24'h000001, 1, 1, 1'b0);
      push_seq(24'h000010, 24'h000001, 1, 1, 1'b0, 0);
      run_q("div_sweep");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Sequencer for the DDS core. Generates the DDS sample-enable tick (`int_dff_en`) and steps the DDS frequency word through a programmable linear sweep: start frequency, signed step, step count, dwell per step, single-shot or looping. Sits between the MCU register bank and the `dds` instance; the DDS consumes `int_dff_en` and `freq_word` directly.

## Interface
- `FW_W`, 24, frequency word width; must match the DDS.
- `DIV_W`, 16, tick divider width.
- `CNT_W`, 16, width of step count and dwell count.

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `div`  in  DIV_W  tick period minus 1; sampled live
- `start`  in  1  one-cycle pulse; begins a sweep when idle
- `abort`  in  1  one-cycle pulse; stops a sweep
- `loop_en`  in  1  1 = restart the sweep after the last step; latched at start
- `f_start`  in  FW_W  first frequency word; latched at start
- `f_step`  in  FW_W  signed two's-complement increment; latched at start
- `n_steps`  in  CNT_W  number of increments after `f_start`; latched at start
- `dwell`  in  CNT_W  ticks per frequency minus 1; latched at start
- `int_dff_en`  out  1  DDS sample tick, one cycle wide
- `freq_word`  out  FW_W  to DDS `freq_word`
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse at natural end of a single-shot sweep

## Operation
- Reset values: `int_dff_en`=0, `freq_word`=0, `busy`=0, `done`=0; all counters 0; state IDLE.
- Tick generator runs free in every state. `div_cnt` increments each cycle. When `div_cnt >= div`, `int_dff_en`=1 for that cycle and `div_cnt` returns to 0. `div`=0 gives a tick every cycle. Lowering `div` below `div_cnt` forces a tick on the next cycle.
- States are IDLE and RUN.
- IDLE, `start`=1 and `abort`=0:
  - latch config.
  - `freq_word`=`f_start`, `dwell_cnt`=0, `step_cnt`=0.
  - `busy`=1, go to RUN.
- RUN, on each tick:
  - If `dwell_cnt` < `dwell`, `dwell_cnt`++.
  - Otherwise `dwell_cnt`=0, and then:
    - `step_cnt` < `n_steps`: `freq_word` += `f_step` (mod 2^FW_W, wraps silently), `step_cnt`++.
    - `step_cnt`==`n_steps` with `loop_en`=1: `freq_word`=`f_start`, `step_cnt`=0.
    - `step_cnt`==`n_steps` with `loop_en`=0: go to IDLE, `busy`=0, `done` pulse; `freq_word` holds the last value.
- Each frequency is held for `dwell`+1 ticks. A single-shot sweep lasts (`n_steps`+1)·(`dwell`+1) ticks.
- `n_steps`=0 outputs `f_start` only.
- `abort` in RUN takes priority over the tick. Next cycle: IDLE, `busy`=0, no `done`, `freq_word` holds.
- `start` while in RUN is ignored. `abort` while in IDLE is ignored. `start` and `abort` in the same cycle in IDLE: `abort` wins and nothing starts.
- Changing config inputs during RUN has no effect until the next start. `div` is the exception: it is live.

## Timing
- `start` sampled at edge N: `busy` and `freq_word`=`f_start` are valid after edge N; `dwell_cnt` is reset.
- The first tick counted toward dwell is the first `int_dff_en` after edge N.
- `freq_word` updates at the edge that consumes the final dwell tick; the new value is visible in the following cycle.
- The DDS therefore uses the new word starting on the next tick.
- `done` rises together with `busy` falling, for exactly one cycle.
- All outputs are registered. No combinational path from inputs to outputs.
- Reset asserted mid-sweep returns every output to its reset value immediately, asynchronously.

## Structure
- Shared package `dds_pkg`: default widths (FW_W, DIV_W, CNT_W) and the state encoding (IDLE, RUN), so the DDS, this block and the register bank agree.
- One sub-module `dds_tick_gen`: the free-running divider (`clk`, `rst_n`, `div` → `int_dff_en`). It is reusable by other sample-rate consumers.
- The sweep FSM stays in the top module.

## Test plan
- Reset check: hold `rst_n`=0, then release → all outputs 0. With `div`=3, `int_dff_en` pulses every 4th cycle.
- Single-shot sweep with `div`=0, `f_start`=0x000100, `f_step`=0x000010, `n_steps`=3, `dwell`=1:
  - `freq_word` reads 0x100, 0x110, 0x120, 0x130, each for 2 cycles.
  - Then `done` pulses once; `busy`=0; `freq_word` stays 0x130.
- Loop and wrap with `loop_en`=1, `f_start`=0xFFFFF0, `f_step`=0x000010, `n_steps`=2, `dwell`=0:
  - sequence is 0xFFFFF0, 0x000000, 0x000010, 0xFFFFF0, …
  - `done` never asserts.
- Negative step with `f_step`=0xFFFFFF (−1), `f_start`=5, `n_steps`=5 → `freq_word` descends 5…0, then `done`.
- Abort mid-sweep: pulse `abort` during the third step → `busy`=0 next cycle, no `done`, `freq_word` frozen.
  - A `start` issued during RUN is ignored.
  - `start` and `abort` pulsed together in IDLE → nothing starts.
- Live `div` change from 9 to 2 while `div_cnt`=7 → tick on the next cycle, then every 3 cycles; sweep dwell counts ticks, not cycles.
